// File: rtl/cfs_apb_master_arb.sv
// cfs_apb_master_arb
// Two-requester round-robin arbiter in front of a single APB requester port.
// A request is granted in IDLE (req_ready pulses combinationally), then runs
// SETUP -> ACCESS. The completion arrives one cycle after the ACCESS cycle that
// saw pready, or after TIMEOUT_CYCLES ACCESS cycles without it (0 = never).
//
// Ports
//   pclk, preset          clock / async active-high reset
//   req_valid/addr/write/wdata  per-requester request, requester i in slice i
//   req_ready             one-cycle accept pulse (IDLE only)
//   rsp_valid             one-cycle completion pulse to the granted requester
//   rsp_rdata, rsp_err    shared response payload, valid with rsp_valid
//   paddr..pwdata         APB requester outputs
//   pready, prdata, pslverr  APB completer inputs
module cfs_apb_master_arb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [1:0]              req_valid,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]              req_write,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    pwrite,
    output logic                    psel,
    output logic                    penable,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    // Timeout fires on the ACCESS cycle whose pre-increment count is N-1,
    // so exactly N ACCESS cycles are spent before the abort.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rr_q;      // requester favoured when both are valid
    logic        gnt_q;     // requester owning the current transfer
    logic [15:0] wait_q;
    logic        gnt_idx;
    logic        take;
    logic        timeout;
    logic        done;

    always_comb begin
        take    = (state_q == IDLE) && (req_valid != 2'b00);
        gnt_idx = (req_valid == 2'b11) ? rr_q : req_valid[1];
        timeout = TO_EN && !pready && (wait_q == TO_LAST);
        done    = (state_q == ACCESS) && (pready || timeout);
    end

    assign req_ready = take ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            gnt_q     <= 1'b0;
            wait_q    <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= 2'b00;
            if (take) begin
                gnt_q  <= gnt_idx;
                rr_q   <= ~gnt_idx;
                paddr  <= gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_addr[ADDR_WIDTH-1:0];
                pwrite <= gnt_idx ? req_write[1] : req_write[0];
                pwdata <= gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wdata[DATA_WIDTH-1:0];
            end
            if (state_q == SETUP)
                wait_q <= '0;
            else if (state_q == ACCESS && !pready)
                wait_q <= wait_q + 16'd1;
            if (done) begin
                rsp_valid <= gnt_q ? 2'b10 : 2'b01;
                // completer fields only count when pready; a timeout is an error
                rsp_err   <= pready ? pslverr : 1'b1;
                rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_cfs_apb_master_arb.sv
module tb_cfs_apb_master_arb;

    localparam logic [31:0] RD = 32'h1234_5678;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [1:0]  req_write;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    always #5 pclk = ~pclk;

    cfs_apb_master_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;

    // completer model controls
    int          slv_wait  = 0;
    logic        slv_hang  = 1'b0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = RD;
    int          acc_n     = 0;

    // monitor state
    int          psel_cnt    = 0;
    int          pen_cnt     = 0;
    logic [31:0] pw_first    = '0;
    logic        pw_unstable = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Completer: answers after slv_wait wait states; garbage on prdata/pslverr otherwise
    initial begin
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                pready  = !slv_hang && (acc_n == slv_wait);
                prdata  = pready ? slv_rdata : $urandom;
                pslverr = pready ? slv_err : 1'($urandom);
                acc_n++;
            end else begin
                pready = 1'b0;
                acc_n  = 0;
            end
        end
    end

    // Monitor: bus activity counters and scoreboard pop on every response
    initial begin
        forever begin
            @(negedge pclk);
            #2;
            if (psel) psel_cnt++;
            if (penable) pen_cnt++;
            if (psel && !penable) pw_first = pwdata;
            if (psel && penable && pwdata !== pw_first) pw_unstable = 1'b1;
            if (req_ready != 2'b00)
                chk("rdy_onehot_idle", {62'd0, psel, $onehot(req_ready)}, 64'd1);
            if (rsp_valid != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_who", rsp_valid, e.who);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    task automatic clr_cnt();
        psel_cnt = 0; pen_cnt = 0; pw_unstable = 1'b0;
    endtask

    // Call at a negedge; returns at negedge+1 of the grant cycle.
    task automatic wait_grant(input string tag, input logic [1:0] exp,
                              input logic [31:0] rd, input logic er);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge pclk); #1; n++;
        end
        chk(tag, req_ready, exp);
        if (req_ready != 2'b00) sbq.push_back('{who: exp, rdata: rd, err: er});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge pclk); #3; n++;
        end
        chk(tag, sbq.size(), 0);
    endtask

    initial begin
        time tprev;
        int  n;
        preset = 1'b1; req_valid = 2'b00; req_addr = '0; req_write = 2'b00; req_wdata = '0;

        // reset state
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", {pwrite, pwdata}, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(negedge pclk);
        preset = 1'b0;

        // contention: grant order 0,1,0,1 spaced 3 cycles; requester 1 writes
        @(negedge pclk);
        slv_wait = 0; slv_err = 1'b0; slv_rdata = RD;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_wdata = {32'hBEEF_0001, 32'h0};
        req_write = 2'b10;
        req_valid = 2'b11;
        tprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("rr_grant%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10,
                       (k % 2 == 0) ? RD : 32'h0, 1'b0);
            chk($sformatf("rr_psel_at_grant%0d", k), psel, 0);
            if (k > 0) chk($sformatf("rr_gap%0d", k), $time - tprev, 30);
            tprev = $time;
            @(negedge pclk);
        end
        req_valid = 2'b00;
        drain("rr_drain");

        // single read from requester 0, zero wait states
        @(negedge pclk);
        clr_cnt();
        slv_rdata = 32'hCAFE_F00D;
        req_addr = {32'h0, 32'h0000_0010}; req_write = 2'b00; req_valid = 2'b01;
        wait_grant("rd_grant", 2'b01, 32'hCAFE_F00D, 1'b0);
        @(negedge pclk);
        req_valid = 2'b00;
        #1;
        chk("rd_setup", {psel, penable}, 2'b10);
        chk("rd_paddr", paddr, 32'h10);
        drain("rd_drain");
        chk("rd_psel_cycles", psel_cnt, 2);
        chk("rd_pen_cycles", pen_cnt, 1);

        // timeout on requester 1 read: completer never answers
        @(negedge pclk);
        clr_cnt();
        slv_hang = 1'b1;
        req_addr = {32'h0000_0300, 32'h0}; req_write = 2'b00; req_valid = 2'b10;
        wait_grant("to_grant", 2'b10, 32'h0, 1'b1);
        @(negedge pclk);
        req_valid = 2'b00;
        drain("to_drain");
        chk("to_pen_cycles", pen_cnt, 4);
        chk("to_psel_cycles", psel_cnt, 5);
        chk("to_psel_after", psel, 0);
        slv_hang = 1'b0;

        // write with 3 wait states and slave error
        @(negedge pclk);
        clr_cnt();
        slv_wait = 3; slv_err = 1'b1;
        req_addr = {32'h0, 32'h0000_0004}; req_wdata = {32'h0, 32'h0000_0055};
        req_write = 2'b01; req_valid = 2'b01;
        wait_grant("ws_grant", 2'b01, 32'h0, 1'b1);
        @(negedge pclk);
        req_valid = 2'b00;
        drain("ws_drain");
        chk("ws_pen_cycles", pen_cnt, 4);
        chk("ws_pwdata_stable", pw_unstable, 0);
        chk("ws_hold_idle", {psel, paddr, pwdata}, {1'b0, 32'h4, 32'h55});
        slv_wait = 0; slv_err = 1'b0;

        // reset during a wait state; pointer currently favours requester 1
        @(negedge pclk);
        slv_hang = 1'b1;
        req_addr = {32'h0, 32'h0000_0020}; req_write = 2'b00; req_valid = 2'b01;
        #1;
        chk("rst_mid_grant", req_ready, 2'b01);
        @(negedge pclk);
        req_valid = 2'b00;
        n = 0;
        while (!penable && n < 10) begin @(negedge pclk); n++; end
        @(negedge pclk);
        chk("rst_mid_in_access", penable, 1);
        #1 preset = 1'b1;
        #1;
        chk("rst_mid_bus_drop", {psel, penable}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk); #3;
            chk($sformatf("rst_mid_no_rsp%0d", k), rsp_valid, 0);
        end
        @(negedge pclk);
        preset = 1'b0; slv_hang = 1'b0; slv_rdata = RD;
        req_addr = {32'h0000_0040, 32'h0000_0030}; req_write = 2'b00; req_valid = 2'b11;
        wait_grant("rst_first_grant", 2'b01, RD, 1'b0);
        @(negedge pclk);
        wait_grant("rst_second_grant", 2'b10, RD, 1'b0);
        @(negedge pclk);
        req_valid = 2'b00;
        drain("rst_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cfs_apb_master_arb.md
CFS_APB_MASTER_ARB -- requirements
Module: cfs_apb_master_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width (1..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (8, 16 or 32).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, max ACCESS cycles without pready before abort; 0 = timeout disabled; range 0..65535.
REQ-004 SHALL have port pclk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port preset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  2  per-requester transfer request; index 0 = requester 0.
REQ-007 SHALL have port req_addr  input  2*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port req_write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-009 SHALL have port req_wdata  input  2*DATA_WIDTH  per-requester write data; same packing as req_addr.
REQ-010 SHALL have port req_ready  output  2  one-cycle accept pulse per requester.
REQ-011 SHALL have port rsp_valid  output  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, shared; valid while any rsp_valid bit is 1.
REQ-013 SHALL have port rsp_err  output  1  error flag, shared; valid while any rsp_valid bit is 1.
REQ-014 SHALL have ports paddr (ADDR_WIDTH), pwrite (1), psel (1), penable (1) and pwdata (DATA_WIDTH) as outputs: APB requester signals.
REQ-015 SHALL have ports pready (1), prdata (DATA_WIDTH) and pslverr (1) as inputs: APB completer signals.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-017 IDLE: if any req_valid is 1, SHALL grant one requester combinationally, pulse its req_ready in the same cycle, capture its addr/write/wdata, and go to SETUP.
REQ-018 Arbitration SHALL be round-robin. The priority pointer SHALL favour the requester not granted last. After reset it SHALL favour requester 0. With a single requester valid, that requester SHALL be granted.
REQ-019 SETUP SHALL drive psel=1, penable=0 and go to ACCESS unconditionally after one cycle.
REQ-020 ACCESS SHALL drive psel=1, penable=1 and remain there until pready=1 or timeout.
REQ-021 paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle. In IDLE they SHALL hold their last values, and psel and penable SHALL both be 0.
REQ-022 On an ACCESS cycle with pready=1:
 - the next cycle SHALL pulse rsp_valid[granted] for exactly one cycle;
 - in that cycle, rsp_err SHALL equal the sampled pslverr;
 - in that cycle, rsp_rdata SHALL equal the sampled prdata for reads and 0 for writes;
 - the FSM SHALL return to IDLE.
REQ-023 A 16-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0. At count == TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0):
 - the FSM SHALL deassert psel and penable next cycle and return to IDLE;
 - rsp_valid[granted] SHALL pulse with rsp_err=1 and rsp_rdata=0.
REQ-024 Minimum transfer cost SHALL be 3 cycles (IDLE grant, SETUP, ACCESS). A new grant SHALL be possible in the cycle rsp_valid pulses.
REQ-025 Requests arriving during SETUP or ACCESS SHALL wait. Requesters SHALL hold req_valid and fields stable until req_ready. req_ready SHALL never be 1 outside IDLE.
REQ-026 pslverr and prdata SHALL be ignored when pready=0.
REQ-027 At most one bit of req_ready and at most one bit of rsp_valid SHALL be 1 in any cycle.

Reset
REQ-028 While preset=1, asynchronously, the block SHALL:
 - set FSM=IDLE and the priority pointer to requester 0;
 - drive psel=0, penable=0, paddr=0, pwrite=0, pwdata=0;
 - drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
 - clear the wait counter.
REQ-029 Reset asserted mid-transfer SHALL drop psel and penable immediately and SHALL generate no rsp_valid for the aborted transfer. The first grant after reset release SHALL follow REQ-018.

Verification
REQ-030 Single read: req_valid=2'b01, addr 0x10, completer pready=1 in the first ACCESS cycle with prdata 0xCAFEF00D -> psel high 2 cycles, rsp_valid=2'b01 with rdata 0xCAFEF00D, err=0.
REQ-031 Contention: both requesters valid continuously for 4 transfers -> grant order 0,1,0,1; each transfer is 3 cycles apart; no overlap of psel.
REQ-032 Wait states and error: write 0x55 to 0x4; pready low 3 ACCESS cycles, then high with pslverr=1 -> penable high 4 cycles, pwdata stable at 0x55, rsp_err=1, rsp_rdata=0.
REQ-033 Timeout: TIMEOUT_CYCLES=4, pready held 0 -> after 4 ACCESS cycles psel=0, rsp_valid pulses with rsp_err=1, rsp_rdata=0.
REQ-034 Reset in ACCESS: assert preset during wait state -> psel/penable 0 without a clock edge, no rsp_valid. After release with both requesters valid -> requester 0 is granted first.
